// File: rtl/alu_seq_muldiv.sv
// Handshaked ALU: 1-cycle logic/arith/shift/compare, iterative radix-2 multiply and (ALU_SEQ_DIV_EN) restoring divide.
// Latency: 1 cycle after accept for single-cycle ops, WIDTH+1 cycles for mult/div.
// Backpressure: result held with out_valid until out_ready; in_ready only while idle.
module alu_seq_muldiv #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               zero_q, zero_d;

    logic [WIDTH-1:0]   alu_lo;
    logic               sgn, is_mul;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_acc, step_q;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

`ifdef ALU_SEQ_DIV_EN
    logic               div_q, div_d;
    logic               rneg_q, rneg_d;
    logic               is_div, b_zero, r_ge;
    logic [WIDTH:0]     r_shift, r_sub;
`endif

    always_comb begin
        alu_lo = '0;
        casez (op)
            5'b00000: alu_lo = a & b;
            5'b00001: alu_lo = a | b;
            5'b00010: alu_lo = ~(a | b);
            5'b00011: alu_lo = a ^ b;
            5'b00100: alu_lo = a + b;
            5'b00101: alu_lo = b - a;
            5'b01000: alu_lo = b << a[SHW-1:0];
            5'b01001: alu_lo = b >> a[SHW-1:0];
            5'b0101?: alu_lo = WIDTH'($signed(b) >>> shamt);
            5'b01100: alu_lo = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            5'b01101: alu_lo = {{(WIDTH-1){1'b0}}, a < b};
            default:  alu_lo = '0;
        endcase
    end

    // Signed variants (op[0]==0) work on magnitudes and fix the sign at the end.
    always_comb begin
        sgn    = ~op[0];
        is_mul = (op[4:1] == 4'b0011);
        abs_a  = (sgn && a[WIDTH-1]) ? ('0 - a) : a;
        abs_b  = (sgn && b[WIDTH-1]) ? ('0 - b) : b;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        step_acc = mul_sum[WIDTH:1];
        step_q   = {mul_sum[0], q_q[WIDTH-1:1]};
        prod     = {step_acc, step_q};
        prod_s   = neg_q ? ('0 - prod) : prod;
        fin_hi   = prod_s[2*WIDTH-1:WIDTH];
        fin_lo   = prod_s[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
        is_div   = (op[4:1] == 4'b1000);
        b_zero   = (b == '0);
        r_shift  = {acc_q, q_q[WIDTH-1]};
        r_ge     = (r_shift >= {1'b0, mcand_q});
        r_sub    = r_shift - {1'b0, mcand_q};
        if (div_q) begin
            step_acc = r_ge ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
            step_q   = {q_q[WIDTH-2:0], r_ge};
            fin_lo   = neg_q  ? ('0 - step_q)   : step_q;
            fin_hi   = rneg_q ? ('0 - step_acc) : step_acc;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        zero_d  = zero_q;
`ifdef ALU_SEQ_DIV_EN
        div_d   = div_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_mul) begin
                        state_d = BUSY;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = '0;
                        q_d     = abs_a;
                        mcand_d = abs_b;
                        neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_SEQ_DIV_EN
                        div_d   = 1'b0;
                        rneg_d  = 1'b0;
                    end else if (is_div) begin
                        // A zero divisor shifts the raw dividend through: lo=all ones, hi=a.
                        state_d = BUSY;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = '0;
                        q_d     = b_zero ? a : abs_a;
                        mcand_d = abs_b;
                        neg_d   = sgn & ~b_zero & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d  = sgn & ~b_zero & a[WIDTH-1];
                        div_d   = 1'b1;
`endif
                    end else begin
                        state_d = DONE;
                        hi_d    = '0;
                        lo_d    = alu_lo;
                        zero_d  = (alu_lo == '0);
                    end
                end
            end
            BUSY: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    hi_d    = fin_hi;
                    lo_d    = fin_lo;
                    zero_d  = (fin_lo == '0);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            zero_q  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zero_q  <= zero_d;
`ifdef ALU_SEQ_DIV_EN
            div_q   <= div_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv at WIDTH=32; divider checks follow ALU_SEQ_DIV_EN.
module tb_alu_seq_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] a, b;
    logic [4:0]   shamt;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] hi, lo;
    logic         zero;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hi        (hi),
        .lo        (lo),
        .zero      (zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for one cycle, then scramble the operands.
    task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [4:0] s);
        in_valid = 1'b1;
        op = o; a = x; b = y; shamt = s;
        tick();
        in_valid = 1'b0;
        op = 5'($urandom_range(0, 31));
        a = $urandom();
        b = $urandom();
        shamt = 5'($urandom_range(0, 31));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " idle_after_accept"}, 64'({in_ready, out_valid}), 64'(2'b10));
    endtask

    task automatic run_single(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [4:0] s,
                              input logic [W-1:0] exp_lo);
        issue(o, x, y, s);
        chk({tag, " out_valid@N+1"}, 64'(out_valid), 64'(1'b1));
        chk({tag, " in_ready"}, 64'(in_ready), 64'(1'b0));
        chk({tag, " hi_lo"}, {hi, lo}, {32'h0, exp_lo});
        chk({tag, " zero"}, 64'(zero), 64'(exp_lo == 32'h0));
        consume(tag);
    endtask

    task automatic run_multi(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                             input logic [W-1:0] exp_lo, input int hold);
        int bad;
        issue(o, x, y, 5'd0);
        bad = 0;
        for (int i = 0; i < W; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            tick();
        end
        chk({tag, " busy_cycles_quiet"}, 64'(bad), 64'(0));
        chk({tag, " out_valid@N+33"}, 64'(out_valid), 64'(1'b1));
        chk({tag, " hi_lo"}, {hi, lo}, {exp_hi, exp_lo});
        chk({tag, " zero"}, 64'(zero), 64'(exp_lo == 32'h0));
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || hi !== exp_hi || lo !== exp_lo) bad++;
        end
        chk({tag, " held_stable"}, 64'(bad), 64'(0));
        consume(tag);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0; a = '0; b = '0; shamt = '0;
        tick();
        tick();
        chk("rst in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst hi_lo", {hi, lo}, 64'h0);
        chk("rst zero", 64'(zero), 64'(1'b0));
        rst_n = 1'b1;
        tick();

        run_single("add", 5'b00100, 32'd5, 32'd7, 5'd0, 32'd12);
        run_single("add_wrap", 5'b00100, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0);
        run_single("sub", 5'b00101, 32'd3, 32'd10, 5'd0, 32'd7);
        run_single("and", 5'b00000, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'h0F000F00);
        run_single("or", 5'b00001, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'hFF0FFF0F);
        run_single("nor", 5'b00010, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'h00F000F0);
        run_single("xor", 5'b00011, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'hF00FF00F);
        run_single("sltu", 5'b01101, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd1);
        run_single("slt", 5'b01100, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0);
        run_single("slt_neg", 5'b01100, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1);
        run_single("sll", 5'b01000, 32'd4, 32'd1, 5'd0, 32'd16);
        run_single("sll_amt_mask", 5'b01000, 32'd36, 32'd1, 5'd0, 32'd16);
        run_single("srl", 5'b01001, 32'd31, 32'h80000000, 5'd0, 32'd1);
        run_single("sra", 5'b01010, 32'd0, 32'h80000000, 5'd4, 32'hF8000000);
        run_single("sra_alt", 5'b01011, 32'd0, 32'h7FFFFFFF, 5'd30, 32'd1);
        run_single("rsv_01110", 5'b01110, 32'd5, 32'd7, 5'd0, 32'd0);
        run_single("rsv_10010", 5'b10010, 32'd5, 32'd7, 5'd0, 32'd0);

        run_multi("mult_neg", 5'b00110, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 10);
        run_multi("multu_max", 5'b00111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_multi("mult_min", 5'b00110, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0);
        run_multi("mult_neg_neg", 5'b00110, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'd2, 0);

`ifdef ALU_SEQ_DIV_EN
        run_multi("divu", 5'b10001, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_multi("div_neg", 5'b10000, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_multi("div_by0", 5'b10000, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 0);
        run_multi("divu_by0", 5'b10001, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 0);
        run_multi("div_neg_by0", 5'b10000, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, 0);
        run_multi("div_min_m1", 5'b10000, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
`else
        run_single("div_as_rsv", 5'b10000, 32'd100, 32'd7, 5'd0, 32'd0);
        run_single("divu_as_rsv", 5'b10001, 32'd100, 32'd7, 5'd0, 32'd0);
`endif

        // Leave a nonzero result in hi/lo, then reset 10 cycles into a multiply.
        run_multi("mult_pre_rst", 5'b00110, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        issue(5'b00111, 32'd12345, 32'd678, 5'd0);
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", 64'(in_ready), 64'(1'b1));
        chk("midrst out_valid", 64'(out_valid), 64'(1'b0));
        chk("midrst hi_lo", {hi, lo}, 64'h0);
        chk("midrst zero", 64'(zero), 64'(1'b0));
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        chk("midrst discarded", 64'(bad), 64'(0));
        run_single("add_after_rst", 5'b00100, 32'd1, 32'd1, 5'd0, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
